// File: rtl/wgt_pingpong_buffer.sv
// Double-buffered weight store. One bank fills from the load stream while the
// other serves whole-block reads; the two banks swap roles as they fill and
// are released.
//
// Load FSM
//   state  | meaning
//   L_IDLE | waiting for a config handshake on an empty fill bank
//   L_FILL | accepting beats into wr_bank
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for a block request on a full read bank
//   R_OUT  | presenting the registered block until the consumer takes it
module wgt_pingpong_buffer #(
    parameter int BUS_W     = 128,
    parameter int OC2_LANES = 16,
    parameter int IC2_LANES = 16,
    parameter int KH        = 3,
    parameter int KW        = 3,
    parameter int DEPTH     = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [$clog2(DEPTH+1)-1:0]                    cfg_nblk,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic                                          wgt_in_valid,
    output logic                                          wgt_in_ready,
    input  logic [BUS_W-1:0]                              wgt_in_data,
    input  logic                                          wgt_in_last,
    output logic                                          load_done,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [$clog2(DEPTH+1)-1:0]                    req_idx,
    input  logic                                          req_release,
    output logic [OC2_LANES*KH*KW*IC2_LANES*2-1:0]        wgt_out,
    output logic                                          wgt_valid,
    input  logic                                          wgt_ready,
    output logic [1:0]                                    bank_full,
    output logic [2:0]                                    err
);

    localparam int BLK_W  = OC2_LANES * KH * KW * IC2_LANES * 2;
    localparam int BEATS  = BLK_W / BUS_W;
    localparam int IDX_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic L_IDLE = 1'b0;
    localparam logic L_FILL = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_OUT  = 1'b1;

    if (BLK_W % BUS_W != 0) begin : g_width_check
        $error("wgt_pingpong_buffer: block width is not a whole number of bus beats");
    end

    logic               l_state;
    logic               r_state;
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         full_q;
    logic [IDX_W-1:0]   nblk [2];
    logic [BEAT_W-1:0]  beat_cnt;
    logic [IDX_W-1:0]   blk_cnt;
    logic               rel_q;
    logic               load_done_q;
    logic               err_cfg_q;
    logic               err_len_q;
    logic               err_idx_q;
    logic               wgt_valid_q;
    logic [BLK_W-1:0]   wgt_out_q;

    // Stored beat-wise so each load beat is a plain word write.
    logic [BUS_W-1:0]   mem [2][DEPTH][BEATS];
    logic [BLK_W-1:0]   rd_block;

    logic cfg_fire;
    logic cfg_ok;
    logic beat_fire;
    logic last_beat;
    logic last_blk;
    logic fill_done;
    logic fill_abort;
    logic req_fire;
    logic idx_ok;
    logic out_fire;
    logic release_fire;

    assign cfg_ready    = (l_state == L_IDLE) && !full_q[wr_bank];
    assign wgt_in_ready = (l_state == L_FILL);
    assign req_ready    = (r_state == R_IDLE) && full_q[rd_bank];

    assign cfg_fire     = cfg_valid && cfg_ready;
    assign cfg_ok       = (cfg_nblk != '0) && (cfg_nblk <= IDX_W'(DEPTH));
    assign beat_fire    = wgt_in_valid && wgt_in_ready;
    assign last_beat    = (beat_cnt == BEAT_W'(BEATS - 1));
    assign last_blk     = (blk_cnt == (nblk[wr_bank] - IDX_W'(1)));
    assign fill_done    = beat_fire && last_beat && last_blk;
    // An early end marker throws the partial bank away.
    assign fill_abort   = beat_fire && wgt_in_last && !(last_beat && last_blk);

    assign req_fire     = req_valid && req_ready;
    assign idx_ok       = (req_idx < nblk[rd_bank]);
    assign out_fire     = wgt_valid_q && wgt_ready;
    assign release_fire = out_fire && rel_q;

    assign load_done    = load_done_q;
    assign wgt_valid    = wgt_valid_q;
    assign wgt_out      = wgt_out_q;
    assign bank_full    = full_q;
    assign err          = {err_idx_q, err_len_q, err_cfg_q};

    // Gather the addressed block of the read bank into one flat word.
    for (genvar j = 0; j < BEATS; j++) begin : g_gather
        assign rd_block[j*BUS_W +: BUS_W] = mem[rd_bank][req_idx[ADDR_W-1:0]][j];
    end

    // Load sequencing: config latch, beat/block counting, bank completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_state     <= L_IDLE;
            wr_bank     <= 1'b0;
            nblk[0]     <= '0;
            nblk[1]     <= '0;
            beat_cnt    <= '0;
            blk_cnt     <= '0;
            load_done_q <= 1'b0;
            err_cfg_q   <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            load_done_q <= fill_done;
            err_cfg_q   <= cfg_fire && !cfg_ok;
            // A completed bank without its end marker is still kept, but flagged.
            err_len_q   <= fill_abort || (fill_done && !wgt_in_last);
            if (l_state == L_IDLE) begin
                if (cfg_fire && cfg_ok) begin
                    nblk[wr_bank] <= cfg_nblk;
                    beat_cnt      <= '0;
                    blk_cnt       <= '0;
                    l_state       <= L_FILL;
                end
            end else if (beat_fire) begin
                if (fill_done) begin
                    wr_bank <= ~wr_bank;
                    l_state <= L_IDLE;
                end else if (wgt_in_last) begin
                    l_state <= L_IDLE;
                end else if (last_beat) begin
                    beat_cnt <= '0;
                    blk_cnt  <= blk_cnt + IDX_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    // Weight storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            mem[wr_bank][blk_cnt[ADDR_W-1:0]][beat_cnt] <= wgt_in_data;
        end
    end

    // Read sequencing: register the requested block and hold it until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            rd_bank     <= 1'b0;
            rel_q       <= 1'b0;
            wgt_valid_q <= 1'b0;
            wgt_out_q   <= '0;
            err_idx_q   <= 1'b0;
        end else begin
            err_idx_q <= 1'b0;
            if (r_state == R_IDLE) begin
                if (req_fire) begin
                    wgt_out_q   <= idx_ok ? rd_block : '0;
                    err_idx_q   <= !idx_ok;
                    rel_q       <= req_release;
                    wgt_valid_q <= 1'b1;
                    r_state     <= R_OUT;
                end
            end else if (out_fire) begin
                wgt_valid_q <= 1'b0;
                r_state     <= R_IDLE;
                if (rel_q) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    // Bank ownership flags: set by the filler, cleared by the reader; the two
    // never touch the same bank in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 2'b00;
        end else begin
            if (fill_done) begin
                full_q[wr_bank] <= 1'b1;
            end
            if (release_fire) begin
                full_q[rd_bank] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wgt_pingpong_buffer.sv
// Self-checking bench for wgt_pingpong_buffer with random weight data and a
// bank/block-level reference model.
module tb_wgt_pingpong_buffer;

    localparam int BUS_W = 128;
    localparam int OC2   = 16;
    localparam int IC2   = 16;
    localparam int KH    = 3;
    localparam int KW    = 3;
    localparam int DEPTH = 8;
    localparam int BLK_W = OC2 * KH * KW * IC2 * 2;
    localparam int BEATS = BLK_W / BUS_W;
    localparam int IDX_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic [IDX_W-1:0]   cfg_nblk;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               wgt_in_valid;
    logic               wgt_in_ready;
    logic [BUS_W-1:0]   wgt_in_data;
    logic               wgt_in_last;
    logic               load_done;
    logic               req_valid;
    logic               req_ready;
    logic [IDX_W-1:0]   req_idx;
    logic               req_release;
    logic [BLK_W-1:0]   wgt_out;
    logic               wgt_valid;
    logic               wgt_ready;
    logic [1:0]         bank_full;
    logic [2:0]         err;

    wgt_pingpong_buffer #(
        .BUS_W(BUS_W), .OC2_LANES(OC2), .IC2_LANES(IC2), .KH(KH), .KW(KW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_nblk(cfg_nblk), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .wgt_in_valid(wgt_in_valid), .wgt_in_ready(wgt_in_ready),
        .wgt_in_data(wgt_in_data), .wgt_in_last(wgt_in_last),
        .load_done(load_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_release(req_release),
        .wgt_out(wgt_out), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .bank_full(bank_full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole blocks per bank, counts, full flags, bank pointers.
    logic [BLK_W-1:0] m_blk [2][DEPTH];
    int               m_nblk [2];
    bit   [1:0]       m_full;
    int               m_wr;
    int               m_rd;

    int errors = 0;
    int checks = 0;
    int ld_cnt, e0_cnt, e1_cnt, e2_cnt;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (load_done === 1'b1) ld_cnt++;
        if (err[0] === 1'b1) e0_cnt++;
        if (err[1] === 1'b1) e1_cnt++;
        if (err[2] === 1'b1) e2_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clr_counts();
        ld_cnt = 0; e0_cnt = 0; e1_cnt = 0; e2_cnt = 0;
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 2'b00; m_nblk[0] = 0; m_nblk[1] = 0;
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_nblk = '0; wgt_in_valid = 0; wgt_in_last = 0;
        wgt_in_data = '0; req_valid = 0; req_idx = '0; req_release = 0; wgt_ready = 0;
    endtask

    // Configure and stream n blocks; last_at = beat carrying the end marker (-1: none).
    task automatic load_bank(input int n, input int last_at, output int stalls);
        logic [BLK_W-1:0] pend [DEPTH];
        logic [BUS_W-1:0] d;
        int total;
        int tries;
        total = n * BEATS;
        stalls = 0;
        cfg_nblk = IDX_W'(n);
        cfg_valid = 1;
        @(posedge clk); #1;
        cfg_valid = 0;
        for (int g = 0; g < total; g++) begin
            for (int w = 0; w < BUS_W / 32; w++) d[w*32 +: 32] = $urandom;
            wgt_in_data = d;
            wgt_in_last = (g == last_at);
            wgt_in_valid = 1;
            tries = 0;
            while (wgt_in_ready !== 1'b1 && tries < 50) begin
                stalls++; tries++;
                @(posedge clk); #1;
            end
            pend[g / BEATS][(g % BEATS) * BUS_W +: BUS_W] = d;
            @(posedge clk); #1;
            if (g == last_at && g != total - 1) break;
        end
        wgt_in_valid = 0;
        wgt_in_last = 0;
        if (last_at < 0 || last_at == total - 1) begin
            for (int b = 0; b < n; b++) m_blk[m_wr][b] = pend[b];
            m_nblk[m_wr] = n;
            m_full[m_wr] = 1'b1;
            m_wr ^= 1;
        end
    endtask

    // Request one block, stall the consumer for stall_cyc cycles, then take it.
    task automatic read_blk(input int idx, input bit rel, input int stall_cyc,
                            output logic [BLK_W-1:0] got, output int lat, output bit stable);
        int tries;
        req_idx = IDX_W'(idx);
        req_release = rel;
        req_valid = 1;
        wgt_ready = 0;
        tries = 0; lat = -1; stable = 0; got = '0;
        while (req_ready !== 1'b1 && tries < 50) begin
            tries++;
            @(posedge clk); #1;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 0;
        req_release = 0;
        lat = 1;
        while (wgt_valid !== 1'b1 && lat < 20) begin
            lat++;
            @(posedge clk); #1;
        end
        got = wgt_out;
        stable = 1;
        for (int s = 0; s < stall_cyc; s++) begin
            @(posedge clk); #1;
            if (wgt_out !== got || wgt_valid !== 1'b1) stable = 0;
        end
        wgt_ready = 1;
        @(posedge clk); #1;
        wgt_ready = 0;
        if (rel) begin
            m_full[m_rd] = 1'b0;
            m_rd ^= 1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #12;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b exp 1", cfg_ready); end
        checks++; if (wgt_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", wgt_in_ready); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
        checks++; if (wgt_valid !== 1'b0) begin errors++; $display("FAIL rst_wgt_valid: got %b exp 0", wgt_valid); end
        checks++; if (wgt_out !== '0) begin errors++; $display("FAIL rst_wgt_out: got[63:0] %h exp 0", wgt_out[63:0]); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b exp 0", load_done); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b exp 000", err); end
        checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full: got %b exp 00", bank_full); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int st;
        clr_counts();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_cfg_ready_pre: got %b exp 1", cfg_ready); end
        load_bank(2, 2 * BEATS - 1, st);
        checks++; if (st != 0) begin errors++; $display("FAIL load_stalls: got %0d exp 0", st); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_timing: got %b exp 1", load_done); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL load_bank_full: got %b exp %b", bank_full, m_full); end
        @(posedge clk); #1;
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_width: got %b exp 0", load_done); end
        checks++; if (ld_cnt != 1) begin errors++; $display("FAIL load_done_count: got %0d exp 1", ld_cnt); end
        checks++; if (e1_cnt != 0) begin errors++; $display("FAIL load_err1: got %0d exp 0", e1_cnt); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_cfg_ready_post: got %b exp 1", cfg_ready); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL load_req_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_read();
        logic [BLK_W-1:0] exp, got;
        int lat;
        bit stb;
        clr_counts();
        exp = m_blk[m_rd][1];
        read_blk(1, 0, 0, got, lat, stb);
        checks++; if (lat != 1) begin errors++; $display("FAIL read1_latency: got %0d exp 1", lat); end
        checks++; if (got !== exp) begin errors++; $display("FAIL read1_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL read1_bank_full: got %b exp %b", bank_full, m_full); end
        read_blk(1, 0, 0, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL reread1_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        exp = m_blk[m_rd][0];
        read_blk(0, 1, 3, got, lat, stb);
        checks++; if (lat != 1) begin errors++; $display("FAIL read0_latency: got %0d exp 1", lat); end
        checks++; if (got !== exp) begin errors++; $display("FAIL read0_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL read0_stable: got %b exp 1", stb); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL read0_release: got %b exp %b", bank_full, m_full); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL read0_req_ready: got %b exp 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (e2_cnt != 0) begin errors++; $display("FAIL read_err2: got %0d exp 0", e2_cnt); end
    endtask

    task automatic test_concurrent();
        logic [BLK_W-1:0] exp, got;
        int lat, st_w, st0;
        bit stb;
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        load_bank(1, BEATS - 1, st0);
        @(posedge clk); #1;
        clr_counts();
        exp = m_blk[m_rd][0];
        // Release handshake is timed to land on the same edge as the final fill beat.
        fork
            load_bank(1, BEATS - 1, st_w);
            read_blk(0, 1, BEATS - 1, got, lat, stb);
        join
        checks++; if (st_w != 0) begin errors++; $display("FAIL conc_load_stalls: got %0d exp 0", st_w); end
        checks++; if (lat != 1) begin errors++; $display("FAIL conc_read_latency: got %0d exp 1", lat); end
        checks++; if (got !== exp) begin errors++; $display("FAIL conc_read_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL conc_read_stable: got %b exp 1", stb); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL conc_bank_full: got %b exp %b", bank_full, m_full); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL conc_req_ready: got %b exp 1", req_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL conc_cfg_ready: got %b exp 1", cfg_ready); end
        @(posedge clk); #1;
        checks++; if (ld_cnt != 1) begin errors++; $display("FAIL conc_load_done: got %0d exp 1", ld_cnt); end
        exp = m_blk[m_rd][0];
        read_blk(0, 0, 0, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL conc_rd_bank_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
    endtask

    task automatic test_errors();
        int st;
        clr_counts();
        cfg_nblk = '0;
        cfg_valid = 1;
        @(posedge clk); #1;
        cfg_valid = 0;
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL err_cfg0_pulse: got %b exp 001", err); end
        checks++; if (wgt_in_ready !== 1'b0) begin errors++; $display("FAIL err_cfg0_state: got %b exp 0", wgt_in_ready); end
        @(posedge clk); #1;
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_cfg0_width: got %b exp 000", err); end
        cfg_nblk = IDX_W'(DEPTH + 1);
        cfg_valid = 1;
        @(posedge clk); #1;
        cfg_valid = 0;
        checks++; if (wgt_in_ready !== 1'b0) begin errors++; $display("FAIL err_cfg9_state: got %b exp 0", wgt_in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_cfg9_ready: got %b exp 1", cfg_ready); end
        @(posedge clk); #1;
        checks++; if (e0_cnt != 2) begin errors++; $display("FAIL err_cfg_count: got %0d exp 2", e0_cnt); end
        load_bank(2, 9, st);
        @(posedge clk); #1;
        checks++; if (e1_cnt != 1) begin errors++; $display("FAIL err_early_last: got %0d exp 1", e1_cnt); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL err_early_bank_full: got %b exp %b", bank_full, m_full); end
        checks++; if (ld_cnt != 0) begin errors++; $display("FAIL err_early_load_done: got %0d exp 0", ld_cnt); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL err_early_idle: got %b exp 1", cfg_ready); end
        load_bank(2, -1, st);
        @(posedge clk); #1;
        checks++; if (e1_cnt != 2) begin errors++; $display("FAIL err_no_last: got %0d exp 2", e1_cnt); end
        checks++; if (ld_cnt != 1) begin errors++; $display("FAIL err_no_last_done: got %0d exp 1", ld_cnt); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL err_no_last_full: got %b exp %b", bank_full, m_full); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL err_both_full_cfg: got %b exp 0", cfg_ready); end
    endtask

    task automatic test_idx_range();
        logic [BLK_W-1:0] exp, got;
        int lat, idx, exp_e2;
        bit stb;
        clr_counts();
        exp = m_blk[m_rd][0];
        read_blk(0, 1, 0, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL idx_release_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        read_blk(5, 0, 0, got, lat, stb);
        checks++; if (got !== '0) begin errors++; $display("FAIL idx5_zero: got[63:0] %h exp 0", got[63:0]); end
        @(posedge clk); #1;
        checks++; if (e2_cnt != 1) begin errors++; $display("FAIL idx5_err2: got %0d exp 1", e2_cnt); end
        exp_e2 = 1;
        for (int i = 0; i < 8; i++) begin
            idx = (i == 0) ? m_nblk[m_rd] : $urandom_range(0, DEPTH);
            exp = (idx < m_nblk[m_rd]) ? m_blk[m_rd][idx] : '0;
            if (idx >= m_nblk[m_rd]) exp_e2++;
            read_blk(idx, 0, $urandom_range(0, 2), got, lat, stb);
            checks++; if (got !== exp) begin errors++; $display("FAIL idx_rand_data: idx %0d got[63:0] %h exp[63:0] %h", idx, got[63:0], exp[63:0]); end
            checks++; if (stb !== 1'b1) begin errors++; $display("FAIL idx_rand_stable: idx %0d got %b exp 1", idx, stb); end
        end
        @(posedge clk); #1;
        checks++; if (e2_cnt != exp_e2) begin errors++; $display("FAIL idx_rand_err2: got %0d exp %0d", e2_cnt, exp_e2); end
        exp = m_blk[m_rd][1];
        read_blk(1, 1, 0, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL idx_final_data: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL idx_final_full: got %b exp %b", bank_full, m_full); end
    endtask

    task automatic test_reset_midload();
        logic [BLK_W-1:0] exp, got;
        int lat, st;
        bit stb;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_cfg_ready: got %b exp 1", cfg_ready); end
        cfg_nblk = IDX_W'(2);
        cfg_valid = 1;
        @(posedge clk); #1;
        cfg_valid = 0;
        for (int g = 0; g < 19; g++) begin
            wgt_in_data = {4{$urandom}};
            wgt_in_valid = 1;
            @(posedge clk); #1;
        end
        wgt_in_valid = 1;
        #2;
        rst = 1;
        #2;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cfg_ready: got %b exp 1", cfg_ready); end
        checks++; if (wgt_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b exp 0", wgt_in_ready); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_req_ready: got %b exp 0", req_ready); end
        checks++; if (wgt_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wgt_valid: got %b exp 0", wgt_valid); end
        checks++; if (wgt_out !== '0) begin errors++; $display("FAIL mid_rst_wgt_out: got[63:0] %h exp 0", wgt_out[63:0]); end
        checks++; if (err !== 3'b000 || load_done !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses: got err %b done %b exp 000 0", err, load_done); end
        checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL mid_rst_bank_full: got %b exp 00", bank_full); end
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        clr_counts();
        load_bank(2, 2 * BEATS - 1, st);
        @(posedge clk); #1;
        checks++; if (st != 0) begin errors++; $display("FAIL mid_reload_stalls: got %0d exp 0", st); end
        checks++; if (ld_cnt != 1) begin errors++; $display("FAIL mid_reload_done: got %0d exp 1", ld_cnt); end
        checks++; if (bank_full !== m_full) begin errors++; $display("FAIL mid_reload_full: got %b exp %b", bank_full, m_full); end
        exp = m_blk[m_rd][0];
        read_blk(0, 0, 0, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL mid_reload_blk0: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
        exp = m_blk[m_rd][1];
        read_blk(1, 1, 1, got, lat, stb);
        checks++; if (got !== exp) begin errors++; $display("FAIL mid_reload_blk1: got[63:0] %h exp[63:0] %h", got[63:0], exp[63:0]); end
    endtask

    initial begin
        clr_counts();
        model_reset();
        test_reset();
        test_load();
        test_read();
        test_concurrent();
        test_errors();
        test_idx_range();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
